spike_encoder_array: RTL and testbench

Multi-channel rate-to-spike encoder for the SNN input layer, successor to the single-channel LFSR-based rate coder. It holds a per-channel rate register file written over a simple config port. On each simulation timestep `tick` it sweeps all channels time-multiplexed through one shared LFSR and comparator, then presents a registered spike vector. It adds linear-probability stochastic coding, a deterministic phase-accumulator mode and per-channel refractory suppression.

---
 rtl/spike_encoder_array.sv | 146 ++++++++++++++
 tb/tb_spike_encoder_array.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder_array.sv
// Multi-channel rate-to-spike encoder: per-channel rate registers swept one channel per
// cycle through a shared Galois LFSR / phase adder, with optional refractory suppression.
module spike_encoder_array #(
    parameter int                N_CH      = 16,
    parameter int                FREQ_W    = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 'hB400,
    parameter int                REFRAC    = 0,
    parameter int                AW        = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic              mode,
    input  logic              tick,
    output logic              busy,
    output logic [N_CH-1:0]   spikes,
    output logic              spikes_valid,
    output logic              tick_dropped
);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_SWEEP = 1'b1;
    localparam logic [3:0] REFRAC_LEN  = 4'(REFRAC);

    logic [0:0]        state_q;
    logic [AW-1:0]     ch_q;
    logic              mode_q;
    logic              done_q;
    logic              valid_q;
    logic              drop_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [N_CH-1:0]   shadow_q;
    logic [N_CH-1:0]   spikes_q;

    logic [FREQ_W-1:0] freq_q [N_CH];
    logic [FREQ_W-1:0] acc_q  [N_CH];
    logic [3:0]        refr_q [N_CH];

    logic [FREQ_W-1:0] rnd;
    logic [FREQ_W-1:0] freq_cur;
    logic [FREQ_W-1:0] acc_cur;
    logic [FREQ_W-1:0] acc_d;
    logic [3:0]        refr_cur;
    logic              carry;
    logic              cand;
    logic              spike_bit;
    logic              last_ch;
    logic              sweeping;

    // Shared datapath: evaluates only the channel currently selected by ch_q.
    always_comb begin
        rnd       = lfsr_q[LFSR_W-1 -: FREQ_W];
        lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        freq_cur  = freq_q[ch_q];
        acc_cur   = acc_q[ch_q];
        refr_cur  = refr_q[ch_q];
        {carry, acc_d} = {1'b0, acc_cur} + {1'b0, freq_cur};
        cand      = mode_q ? carry : (rnd < freq_cur);
        spike_bit = cand && (refr_cur == 4'd0);
        last_ch   = (ch_q == AW'(N_CH - 1));
        sweeping  = (state_q == STATE_SWEEP);
    end

    // Per-channel state; a same-cycle write and sweep of a channel sees the old rate.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic hit;
            assign hit = sweeping && (ch_q == AW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    freq_q[gi] <= '0;
                    acc_q[gi]  <= '0;
                    refr_q[gi] <= '0;
                end else begin
                    if (cfg_we && (cfg_addr == AW'(gi))) begin
                        freq_q[gi] <= cfg_freq;
                    end
                    if (hit) begin
                        acc_q[gi] <= acc_d;
                        if (spike_bit) begin
                            refr_q[gi] <= REFRAC_LEN;
                        end else if (refr_q[gi] != 4'd0) begin
                            refr_q[gi] <= refr_q[gi] - 4'd1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STATE_IDLE;
            ch_q     <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            lfsr_q   <= (seed == '0) ? LFSR_W'(1) : seed;
            shadow_q <= '0;
            spikes_q <= '0;
        end else begin
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
            // Publish one edge after the last channel so the output stage stays registered.
            if (done_q) begin
                spikes_q <= shadow_q;
                valid_q  <= 1'b1;
            end
            case (state_q)
                STATE_IDLE: begin
                    if (tick) begin
                        state_q  <= STATE_SWEEP;
                        ch_q     <= '0;
                        mode_q   <= mode;
                        shadow_q <= '0;
                    end
                end
                default: begin
                    drop_q         <= tick;
                    lfsr_q         <= lfsr_d;
                    shadow_q[ch_q] <= spike_bit;
                    if (last_ch) begin
                        state_q <= STATE_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        ch_q <= ch_q + AW'(1);
                    end
                end
            endcase
        end
    end

    assign busy         = (state_q == STATE_SWEEP);
    assign spikes       = spikes_q;
    assign spikes_valid = valid_q;
    assign tick_dropped = drop_q;

endmodule

// File: tb/tb_spike_encoder_array.sv
// Scoreboard bench for spike_encoder_array: a behavioural model queues the expected spike
// vector at each tick; the monitor pops and compares on every spikes_valid pulse.
module tb_spike_encoder_array;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seed;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_freq;
    logic        mode;
    logic        tick;

    logic          busy0, valid0, drop0;
    logic [N-1:0]  spikes0;
    logic          busy2, valid2, drop2;
    logic [N-1:0]  spikes2;

    always #5 clk = ~clk;

    spike_encoder_array #(.N_CH(N), .FREQ_W(8), .LFSR_W(16), .LFSR_TAPS(16'hB400), .REFRAC(0)) u_dut0 (
        .clk(clk), .rst(rst), .seed(seed), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .mode(mode), .tick(tick), .busy(busy0), .spikes(spikes0),
        .spikes_valid(valid0), .tick_dropped(drop0)
    );

    spike_encoder_array #(.N_CH(N), .FREQ_W(8), .LFSR_W(16), .LFSR_TAPS(16'hB400), .REFRAC(2)) u_dut2 (
        .clk(clk), .rst(rst), .seed(seed), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .mode(mode), .tick(tick), .busy(busy2), .spikes(spikes2),
        .spikes_valid(valid2), .tick_dropped(drop2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic [7:0]  m_freq [N];
    logic [7:0]  m_acc  [N];
    int          m_refr [N];
    logic [15:0] q0 [$];
    logic [15:0] q2 [$];

    task automatic model_reset();
        m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
        for (int c = 0; c < N; c++) begin
            m_freq[c] = 8'h0;
            m_acc[c]  = 8'h0;
            m_refr[c] = 0;
        end
        q0.delete();
        q2.delete();
    endtask

    task automatic model_sweep(input logic md);
        logic [15:0] v0;
        logic [15:0] v2;
        logic [7:0]  r;
        logic [8:0]  s;
        logic        cand;
        v0 = '0;
        v2 = '0;
        for (int c = 0; c < N; c++) begin
            r      = m_lfsr[15:8];
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            s        = {1'b0, m_acc[c]} + {1'b0, m_freq[c]};
            m_acc[c] = s[7:0];
            cand     = md ? s[8] : (r < m_freq[c]);
            v0[c]    = cand;
            if (cand && m_refr[c] == 0) begin
                v2[c]     = 1'b1;
                m_refr[c] = 2;
            end else if (m_refr[c] > 0) begin
                m_refr[c] = m_refr[c] - 1;
            end
        end
        q0.push_back(v0);
        q2.push_back(v2);
    endtask

    // ---------------- monitor ----------------
    logic [15:0] e0, e2;
    always @(negedge clk) begin
        if (valid0) begin
            n_valid++;
            check("q0_has_entry", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check("spikes_refrac0", 32'(spikes0), 32'(e0));
            end
            $display("sweep %0d: spikes=%h refrac_spikes=%h", n_valid, spikes0, spikes2);
        end
        if (valid2) begin
            check("q2_has_entry", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                check("spikes_refrac2", 32'(spikes2), 32'(e2));
            end
        end
    end

    // ---------------- stimulus helpers (all start and end on a negedge) ----------------
    task automatic do_reset(input logic [15:0] s);
        @(negedge clk);
        seed = s;
        rst  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg(input int a, input int f);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a[3:0];
        cfg_freq = f[7:0];
        @(negedge clk);
        cfg_we    = 1'b0;
        m_freq[a] = f[7:0];
    endtask

    task automatic fast_sweep(input logic md, output logic [15:0] sp0, output logic [15:0] sp2);
        int k;
        tick = 1'b1;
        mode = md;
        model_sweep(md);
        @(negedge clk);
        tick = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid0 && k < 40);
        check("latency", k, 17);
        check("valid2_aligned", 32'(valid2), 32'd1);
        sp0 = spikes0;
        sp2 = spikes2;
    endtask

    // Events are given as the edge index relative to the accepting edge E0.
    task automatic corner_sweep(input logic md, input int drop_e, input int cfg_e, input int rst_e,
                                output int vk, output int drops);
        vk    = -1;
        drops = 0;
        tick  = 1'b1;
        mode  = md;
        model_sweep(md);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid0 && vk < 0) vk = k;
            if (drop0) drops++;
            tick   = (k + 1 == drop_e);
            mode   = (k == 1) ? ~md : md;
            cfg_we = (k + 1 == cfg_e);
            if (k + 1 == cfg_e) m_freq[cfg_addr] = cfg_freq;
            rst = (k + 1 == rst_e);
            if (k + 1 == rst_e) model_reset();
        end
        mode = md;
    endtask

    // ---------------- main sequence ----------------
    int          vk, dr, bad, miss, e64, c255, er;
    int          cnt [N];
    logic [15:0] sp0, sp2;

    initial begin
        rst = 1'b0; tick = 1'b0; cfg_we = 1'b0; mode = 1'b0;
        seed = 16'h0; cfg_addr = 4'h0; cfg_freq = 8'h0;

        // Reset with seed 0, then idle: every output must stay low.
        do_reset(16'h0000);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy0 || valid0 || drop0 || spikes0 != 0 || busy2 || valid2 || drop2 || spikes2 != 0)
                bad++;
        end
        check("idle_outputs_low", bad, 0);
        corner_sweep(1'b0, 0, 0, 0, vk, dr);
        check("first_valid_edge", vk, 17);
        check("first_no_drop", dr, 0);

        // Stochastic extremes and rate accuracy.
        do_reset(16'hACE1);
        cfg(0, 0);
        cfg(1, 255);
        for (int c = 2; c < N; c++) cfg(c, 128);
        for (int c = 0; c < N; c++) cnt[c] = 0;
        for (int s = 0; s < 4096; s++) begin
            fast_sweep(1'b0, sp0, sp2);
            for (int c = 0; c < N; c++) cnt[c] += int'(sp0[c]);
        end
        check("ch0_freq0_spikes", cnt[0], 0);
        miss = 4096 - cnt[1];
        check("ch1_freq255_miss_in_range", 32'(miss > 0 && miss <= 40), 32'd1);
        for (int c = 2; c < N; c++)
            check($sformatf("rate50_ch%0d_in_range", c), 32'(cnt[c] >= 1926 && cnt[c] <= 2170), 32'd1);

        // Deterministic phase mode and refractory suppression.
        do_reset(16'h1234);
        cfg(0, 64);
        cfg(1, 255);
        cfg(2, 37);
        cfg(3, 200);
        e64 = 0; c255 = 0; er = 0;
        for (int n = 1; n <= 256; n++) begin
            fast_sweep(1'b1, sp0, sp2);
            if (sp0[0] != (n % 4 == 0)) e64++;
            c255 += int'(sp0[1]);
            if (sp2[1] != (n >= 2 && (n - 2) % 3 == 0)) er++;
        end
        check("phase64_pattern_errors", e64, 0);
        check("phase255_spike_count", c255, 255);
        check("refrac2_pattern_errors", er, 0);

        // Handshake corners: dropped ticks, same-cycle config write, mid-sweep reset.
        corner_sweep(1'b1, 5, 0, 0, vk, dr);
        check("drop_e5_pulses", dr, 1);
        check("drop_e5_valid_edge", vk, 17);
        corner_sweep(1'b1, 16, 0, 0, vk, dr);
        check("drop_e16_pulses", dr, 1);
        check("drop_e16_valid_edge", vk, 17);
        cfg_addr = 4'd3;
        cfg_freq = 8'd10;
        corner_sweep(1'b0, 0, 4, 0, vk, dr);
        check("cfg_ch3_valid_edge", vk, 17);
        fast_sweep(1'b0, sp0, sp2);
        corner_sweep(1'b0, 0, 0, 8, vk, dr);
        check("rst_midsweep_no_valid", vk, -1);
        check("rst_midsweep_spikes0", 32'(spikes0), 32'd0);
        check("rst_midsweep_spikes2", 32'(spikes2), 32'd0);
        check("rst_midsweep_busy", 32'(busy0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
